// File: rtl/wb_write_arbiter_if.sv
// wb_write_arbiter_if
//   Bundles the writeback arbiter's pipeline, long-latency, register file
//   and hazard-check signals.
//   master : environment side (MEM stage, long-latency units, decode, regfile)
//   slave  : arbiter side
//   Signals:
//     stall_i, mem_wreg, mem_wd, mem_wdata   MEM/WB pipeline write request
//     lu_valid, lu_addr, lu_data, lu_ready   long-latency result handshake
//     wr_en, wraddr, wrdata                  register file write port
//     chk_addr1/2, pend_hit1/2, pend_cnt     decode hazard check, FIFO fill
interface wb_write_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic              stall_i;
  logic              mem_wreg;
  logic [ADDR_W-1:0] mem_wd;
  logic [DATA_W-1:0] mem_wdata;
  logic              lu_valid;
  logic [ADDR_W-1:0] lu_addr;
  logic [DATA_W-1:0] lu_data;
  logic              lu_ready;
  logic              wr_en;
  logic [ADDR_W-1:0] wraddr;
  logic [DATA_W-1:0] wrdata;
  logic [ADDR_W-1:0] chk_addr1;
  logic [ADDR_W-1:0] chk_addr2;
  logic              pend_hit1;
  logic              pend_hit2;
  logic [CNT_W-1:0]  pend_cnt;

  modport master (
    output stall_i, mem_wreg, mem_wd, mem_wdata,
    output lu_valid, lu_addr, lu_data,
    output chk_addr1, chk_addr2,
    input  lu_ready, wr_en, wraddr, wrdata,
    input  pend_hit1, pend_hit2, pend_cnt
  );

  modport slave (
    input  stall_i, mem_wreg, mem_wd, mem_wdata,
    input  lu_valid, lu_addr, lu_data,
    input  chk_addr1, chk_addr2,
    output lu_ready, wr_en, wraddr, wrdata,
    output pend_hit1, pend_hit2, pend_cnt
  );
endinterface

// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter
//   Writeback-side driver of the register file write port. MEM-stage results
//   are registered straight through (MEM/WB boundary); results from
//   long-latency units wait in a small FIFO and drain into cycles the
//   pipeline leaves free. Decode is told which registers still have a
//   buffered result so it can stall operand reads.
//   Ports:
//     clk  clock, all state on posedge
//     rst  asynchronous active-low reset
//     bus  wb_write_arbiter_if.slave (see interface file for signal list)
module wb_write_arbiter #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  wb_write_arbiter_if.slave     bus
);
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // Output flops
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wraddr_q, wraddr_d;
  logic [DATA_W-1:0] wrdata_q, wrdata_d;

  // FIFO control
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PTR_W-1:0]  head_q, head_d;
  logic [PTR_W-1:0]  tail_q, tail_d;
  logic [DEPTH-1:0]  valid_q, valid_d;

  // FIFO storage (no reset needed; valid_q qualifies every entry)
  logic [ADDR_W-1:0] fifo_addr_q [DEPTH];
  logic [DATA_W-1:0] fifo_data_q [DEPTH];

  logic pipe_wr;
  logic pop;
  logic push;
  logic lu_ready;
  logic [DEPTH-1:0] hit1_vec;
  logic [DEPTH-1:0] hit2_vec;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    ptr_inc = (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Pipeline writes always win; r0 writes are dropped and free the slot.
  assign pipe_wr  = !bus.stall_i && bus.mem_wreg && (bus.mem_wd != '0);
  assign pop      = !pipe_wr && (cnt_q != '0);
  // Ready looks only at the registered count: a full FIFO refuses a push
  // even in a cycle that pops, which keeps lu_ready free of pipeline timing.
  assign lu_ready = (cnt_q < CNT_W'(DEPTH));
  // lu_addr==0 completes the handshake but is never stored.
  assign push     = bus.lu_valid && lu_ready && (bus.lu_addr != '0);

  always_comb begin
    wr_en_d  = pipe_wr || pop;
    wraddr_d = wraddr_q;
    wrdata_d = wrdata_q;
    head_d   = head_q;
    tail_d   = tail_q;
    cnt_d    = cnt_q;
    valid_d  = valid_q;

    if (pipe_wr) begin
      wraddr_d = bus.mem_wd;
      wrdata_d = bus.mem_wdata;
    end else if (pop) begin
      wraddr_d = fifo_addr_q[head_q];
      wrdata_d = fifo_data_q[head_q];
    end

    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = ptr_inc(head_q);
    end
    // Push never targets the popped slot: pop needs cnt>0 and push needs
    // cnt<DEPTH, so tail and head cannot coincide when both fire.
    if (push) begin
      valid_d[tail_q] = 1'b1;
      tail_d          = ptr_inc(tail_q);
    end

    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_en_q  <= 1'b0;
      wraddr_q <= '0;
      wrdata_q <= '0;
      cnt_q    <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      valid_q  <= '0;
    end else begin
      wr_en_q  <= wr_en_d;
      wraddr_q <= wraddr_d;
      wrdata_q <= wrdata_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      valid_q  <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr_q[tail_q] <= bus.lu_addr;
      fifo_data_q[tail_q] <= bus.lu_data;
    end
  end

  // Per-entry address compare for the decode hazard check.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_hit
      assign hit1_vec[gi] = valid_q[gi] && (fifo_addr_q[gi] == bus.chk_addr1);
      assign hit2_vec[gi] = valid_q[gi] && (fifo_addr_q[gi] == bus.chk_addr2);
    end
  endgenerate

  // A result being accepted this cycle counts as pending. The value in the
  // output flop does not: the register file forwards wrdata that cycle.
  assign bus.pend_hit1 = (bus.chk_addr1 != '0) &&
                         ((|hit1_vec) || (push && (bus.lu_addr == bus.chk_addr1)));
  assign bus.pend_hit2 = (bus.chk_addr2 != '0) &&
                         ((|hit2_vec) || (push && (bus.lu_addr == bus.chk_addr2)));

  assign bus.lu_ready = lu_ready;
  assign bus.wr_en    = wr_en_q;
  assign bus.wraddr   = wraddr_q;
  assign bus.wrdata   = wrdata_q;
  assign bus.pend_cnt = cnt_q;
endmodule

// File: tb/tb_wb_write_arbiter.sv
module tb_wb_write_arbiter;
  logic clk;
  logic rst;

  wb_write_arbiter_if #(.ADDR_W(5), .DATA_W(32), .DEPTH(2)) bus_if ();

  wb_write_arbiter #(.ADDR_W(5), .DATA_W(32), .DEPTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        stall;
    logic        wreg;
    logic [4:0]  wd;
    logic [31:0] wdata;
    logic        luv;
    logic [4:0]  lua;
    logic [31:0] lud;
    logic [4:0]  c1;
    logic [4:0]  c2;
    logic        e_rdy;
    logic        e_h1;
    logic        e_h2;
    logic        e_en;
    logic [4:0]  e_addr;
    logic [31:0] e_data;
    logic [1:0]  e_cnt;
  } vec_t;

  localparam int NVEC = 20;
  vec_t vecs [NVEC];

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_if.stall_i   = 1'b0;
    bus_if.mem_wreg  = 1'b0;
    bus_if.mem_wd    = '0;
    bus_if.mem_wdata = '0;
    bus_if.lu_valid  = 1'b0;
    bus_if.lu_addr   = '0;
    bus_if.lu_data   = '0;
    bus_if.chk_addr1 = '0;
    bus_if.chk_addr2 = '0;
  endtask

  initial begin
    //          stall wreg  wd     wdata          luv   lua    lud           c1     c2      rdy   h1    h2      en    addr   data           cnt
    vecs[0]  = '{1'b0,1'b1,5'd5, 32'h12345678,1'b0,5'd0, 32'h0,       5'd0, 5'd0,   1'b1,1'b0,1'b0,   1'b1,5'd5, 32'h12345678,2'd0};
    vecs[1]  = '{1'b0,1'b1,5'd0, 32'h0000dead,1'b0,5'd0, 32'h0,       5'd0, 5'd0,   1'b1,1'b0,1'b0,   1'b0,5'd5, 32'h12345678,2'd0};
    vecs[2]  = '{1'b0,1'b1,5'd1, 32'h1,       1'b1,5'd3, 32'hA,       5'd3, 5'd0,   1'b1,1'b1,1'b0,   1'b1,5'd1, 32'h1,       2'd1};
    vecs[3]  = '{1'b0,1'b1,5'd2, 32'h2,       1'b1,5'd7, 32'hB,       5'd3, 5'd7,   1'b1,1'b1,1'b1,   1'b1,5'd2, 32'h2,       2'd2};
    vecs[4]  = '{1'b0,1'b1,5'd3, 32'h3,       1'b1,5'd8, 32'hD,       5'd8, 5'd7,   1'b0,1'b0,1'b1,   1'b1,5'd3, 32'h3,       2'd2};
    vecs[5]  = '{1'b0,1'b1,5'd4, 32'h4,       1'b0,5'd0, 32'h0,       5'd3, 5'd0,   1'b0,1'b1,1'b0,   1'b1,5'd4, 32'h4,       2'd2};
    vecs[6]  = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,       5'd7, 5'd0,   1'b0,1'b1,1'b0,   1'b1,5'd3, 32'hA,       2'd1};
    vecs[7]  = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,       5'd7, 5'd3,   1'b1,1'b1,1'b0,   1'b1,5'd7, 32'hB,       2'd0};
    vecs[8]  = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,       5'd7, 5'd0,   1'b1,1'b0,1'b0,   1'b0,5'd7, 32'hB,       2'd0};
    vecs[9]  = '{1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd6, 32'hC,       5'd6, 5'd0,   1'b1,1'b1,1'b0,   1'b0,5'd7, 32'hB,       2'd1};
    vecs[10] = '{1'b1,1'b1,5'd4, 32'h44,      1'b1,5'd9, 32'h99,      5'd6, 5'd9,   1'b1,1'b1,1'b1,   1'b1,5'd6, 32'hC,       2'd1};
    vecs[11] = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,       5'd6, 5'd9,   1'b1,1'b0,1'b1,   1'b1,5'd9, 32'h99,      2'd0};
    vecs[12] = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,       5'd0, 5'd0,   1'b1,1'b0,1'b0,   1'b0,5'd9, 32'h99,      2'd0};
    vecs[13] = '{1'b0,1'b0,5'd0, 32'h0,       1'b1,5'd0, 32'h55,      5'd0, 5'd0,   1'b1,1'b0,1'b0,   1'b0,5'd9, 32'h99,      2'd0};
    vecs[14] = '{1'b0,1'b1,5'd11,32'h11,      1'b1,5'd10,32'h1,       5'd10,5'd0,   1'b1,1'b1,1'b0,   1'b1,5'd11,32'h11,      2'd1};
    vecs[15] = '{1'b0,1'b1,5'd12,32'h12,      1'b1,5'd10,32'h2,       5'd10,5'd0,   1'b1,1'b1,1'b0,   1'b1,5'd12,32'h12,      2'd2};
    vecs[16] = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,       5'd10,5'd0,   1'b0,1'b1,1'b0,   1'b1,5'd10,32'h1,       2'd1};
    vecs[17] = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,       5'd10,5'd0,   1'b1,1'b1,1'b0,   1'b1,5'd10,32'h2,       2'd0};
    vecs[18] = '{1'b0,1'b0,5'd0, 32'h0,       1'b0,5'd0, 32'h0,       5'd10,5'd0,   1'b1,1'b0,1'b0,   1'b0,5'd10,32'h2,       2'd0};
    vecs[19] = '{1'b1,1'b1,5'd4, 32'h44,      1'b0,5'd0, 32'h0,       5'd0, 5'd0,   1'b1,1'b0,1'b0,   1'b0,5'd10,32'h2,       2'd0};

    // Reset held with a long-latency result offered: nothing may be stored.
    idle_inputs();
    rst = 1'b0;
    bus_if.lu_valid = 1'b1;
    bus_if.lu_addr  = 5'd3;
    bus_if.lu_data  = 32'hA;
    repeat (3) @(posedge clk);
    #1;
    check("rst_wr_en", 32'(bus_if.wr_en), 32'd0);
    check("rst_pend_cnt", 32'(bus_if.pend_cnt), 32'd0);
    @(negedge clk);
    idle_inputs();
    rst = 1'b1;
    #1;
    check("rst_lu_ready", 32'(bus_if.lu_ready), 32'd1);
    check("rst_wraddr", 32'(bus_if.wraddr), 32'd0);
    check("rst_wrdata", bus_if.wrdata, 32'd0);
    @(posedge clk);
    #1;
    check("rst_no_push_cnt", 32'(bus_if.pend_cnt), 32'd0);
    check("rst_no_push_wr_en", 32'(bus_if.wr_en), 32'd0);
    $display("txn reset: wr_en=%0b pend_cnt=%0d lu_ready=%0b",
             bus_if.wr_en, bus_if.pend_cnt, bus_if.lu_ready);

    // Table-driven vectors: combinational outputs checked before the edge,
    // registered outputs just after it.
    for (int i = 0; i < NVEC; i++) begin
      @(negedge clk);
      bus_if.stall_i   = vecs[i].stall;
      bus_if.mem_wreg  = vecs[i].wreg;
      bus_if.mem_wd    = vecs[i].wd;
      bus_if.mem_wdata = vecs[i].wdata;
      bus_if.lu_valid  = vecs[i].luv;
      bus_if.lu_addr   = vecs[i].lua;
      bus_if.lu_data   = vecs[i].lud;
      bus_if.chk_addr1 = vecs[i].c1;
      bus_if.chk_addr2 = vecs[i].c2;
      #1;
      check($sformatf("v%0d_lu_ready", i), 32'(bus_if.lu_ready), 32'(vecs[i].e_rdy));
      check($sformatf("v%0d_pend_hit1", i), 32'(bus_if.pend_hit1), 32'(vecs[i].e_h1));
      check($sformatf("v%0d_pend_hit2", i), 32'(bus_if.pend_hit2), 32'(vecs[i].e_h2));
      @(posedge clk);
      #1;
      check($sformatf("v%0d_wr_en", i), 32'(bus_if.wr_en), 32'(vecs[i].e_en));
      check($sformatf("v%0d_wraddr", i), 32'(bus_if.wraddr), 32'(vecs[i].e_addr));
      check($sformatf("v%0d_wrdata", i), bus_if.wrdata, vecs[i].e_data);
      check($sformatf("v%0d_pend_cnt", i), 32'(bus_if.pend_cnt), 32'(vecs[i].e_cnt));
      $display("txn v%0d: wr_en=%0b wraddr=%0d wrdata=0x%0h pend_cnt=%0d",
               i, bus_if.wr_en, bus_if.wraddr, bus_if.wrdata, bus_if.pend_cnt);
    end

    // Asynchronous reset in mid-cycle with a write in flight and an entry pending.
    @(negedge clk);
    idle_inputs();
    bus_if.mem_wreg  = 1'b1;
    bus_if.mem_wd    = 5'd20;
    bus_if.mem_wdata = 32'h20;
    bus_if.lu_valid  = 1'b1;
    bus_if.lu_addr   = 5'd21;
    bus_if.lu_data   = 32'h21;
    @(posedge clk);
    #1;
    check("mid_wr_en_before", 32'(bus_if.wr_en), 32'd1);
    check("mid_cnt_before", 32'(bus_if.pend_cnt), 32'd1);
    idle_inputs();
    #2;
    rst = 1'b0;
    #1;
    check("mid_async_wr_en", 32'(bus_if.wr_en), 32'd0);
    check("mid_async_cnt", 32'(bus_if.pend_cnt), 32'd0);
    check("mid_async_wraddr", 32'(bus_if.wraddr), 32'd0);
    check("mid_async_wrdata", bus_if.wrdata, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_lu_ready", 32'(bus_if.lu_ready), 32'd1);
    @(posedge clk);
    #1;
    check("mid_entry_lost", 32'(bus_if.wr_en), 32'd0);
    $display("txn midreset: wr_en=%0b pend_cnt=%0d", bus_if.wr_en, bus_if.pend_cnt);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
